button_step_conditioner: RTL and testbench
==========================================

// Module: button_step_conditioner
// PURPOSE
//  Converts two raw, bouncing push-button inputs into clean, single-cycle step commands.
//  Feeds the up/down/EN inputs of the 0..10 up/down digit counter used for time/date setting.
//  Synchronises and debounces each button, then emits one step per press.
//  When enabled, it auto-repeats while a button is held.
//  It never emits up and down in the same cycle.
// PARAMETERS
//  DEB_CYCLES    1000    consecutive stable synchronised cycles required to accept a level change (>=2)
//  HOLD_CYCLES   50000   cycles from the first step to the first auto-repeat step (>=2)
//  REPEAT_CYCLES 10000   cycles between successive auto-repeat steps (>=2)
//  CNT_W         17      width of the shared debounce/hold/repeat timers; must hold max(param)-1
//  BTN_ACT_LOW   0       1: raw buttons read 0 when pressed (inverted at input)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  asynchronous, active-low reset (0 = reset)
//  btn_up     in   1  raw up button, asynchronous to clk
//  btn_down   in   1  raw down button, asynchronous to clk
//  repeat_en  in   1  1: auto-repeat allowed while held; 0: one step per press only
//  up         out  1  one-cycle step-up command
//  down       out  1  one-cycle step-down command
//  EN         out  1  up | down, registered; one-cycle strobe
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all outputs 0
//   - sync FFs, debounced levels db_up/db_dn, and timers all 0
//   - FSM = IDLE
//  Sync: 2-FF synchroniser per button, after the optional BTN_ACT_LOW inversion.
//  Debounce (per button):
//   - counter increments each cycle the synchronised value differs from db.
//   - counter clears when they are equal.
//   - when the counter reaches DEB_CYCLES-1 and they still differ, db toggles and the counter clears.
//   - a glitch shorter than DEB_CYCLES cycles never changes db.
//  Latency: raw input stable high before edge k -> db high after edge k+DEB_CYCLES+1
//   -> step output high after edge k+DEB_CYCLES+2, for exactly 1 cycle.
//  FSM (shared; direction register dir latched on press):
//   - IDLE: db_up & !db_dn -> pulse up, dir=UP, timer=0, go to HOLD.
//   - IDLE: db_dn & !db_up -> pulse down, dir=DN, timer=0, go to HOLD.
//   - IDLE: both high -> go to LOCK, no pulse.
//   - HOLD: db(dir) falls -> IDLE.
//   - HOLD: other button rises -> LOCK, no pulse.
//   - HOLD: repeat_en & timer==HOLD_CYCLES-1 -> pulse dir, timer=0, go to REPEAT.
//   - HOLD: otherwise timer++, saturating when repeat_en=0.
//   - REPEAT: db(dir) falls -> IDLE; other button rises -> LOCK; repeat_en=0 -> HOLD (timer held, no pulses).
//   - REPEAT: timer==REPEAT_CYCLES-1 -> pulse dir, timer=0; else timer++.
//   - LOCK: stays until db_up=0 and db_dn=0, then IDLE. Partial release yields no step.
//  Outputs are registered. up and down are never both 1. EN is 1 only in cycles where up or down is 1.
//  Timer widths: compare on CNT_W bits; no wrap occurs when CNT_W is sized per its rule.
//  Reset asserted mid-hold or mid-pulse: outputs drop to 0 immediately (async).
//   After release, a still-held button must re-debounce before it produces a step.
// TESTING (bench uses DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
//  1. Clean press btn_up=1 at edge 0, held 5 cycles, repeat_en=0 -> up=EN=1 only after edge 6; no further pulses.
//  2. Bounce: btn_down toggles every cycle for 8 cycles, then stays 1 -> exactly one down pulse,
//     4+2 edges after the final rise.
//  3. Hold btn_up 40 cycles, repeat_en=1 -> first pulse at edge 6, then edges 16, 19, 22, ... (period 3);
//     stops within 1 cycle of db_up falling.
//  4. Press up, then press down while holding -> one up pulse, then LOCK; release down only -> no pulse;
//     release up -> IDLE; next clean press works.
//  5. Both pressed in the same cycle -> no pulses at all; up and down never simultaneously 1.
//  6. rst=0 during a REPEAT burst -> outputs 0 asynchronously; rst=1 with btn_up held -> next pulse
//     DEB_CYCLES+3 edges later.

Source files
------------

// File: rtl/button_step_conditioner_if.sv
// Signal bundle between the step conditioner and its user.
// Raw buttons and the repeat enable go in; one-cycle step strobes come out.
interface button_step_conditioner_if;
    logic btn_up;
    logic btn_down;
    logic repeat_en;
    logic up;
    logic down;
    logic EN;

    modport master (
        output btn_up, btn_down, repeat_en,
        input  up, down, EN
    );

    modport slave (
        input  btn_up, btn_down, repeat_en,
        output up, down, EN
    );
endinterface

// File: rtl/button_step_conditioner.sv
// Turns two raw bouncing push-buttons into clean one-cycle up/down step strobes,
// with optional auto-repeat while a button is held and a lockout when both are pressed.
module button_step_conditioner #(
    parameter int unsigned DEB_CYCLES    = 1000,
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned REPEAT_CYCLES = 10000,
    parameter int unsigned CNT_W         = 17,
    parameter bit          BTN_ACT_LOW   = 1'b0
) (
    input logic                      clk,
    input logic                      rst,
    button_step_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT,
        S_LOCK
    } state_t;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [CNT_W-1:0] deb_cnt [2];

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             step_up, step_dn;
    logic             db_dir, db_oth;
    logic             up_q, down_q, en_q;

    assign raw = {bus.btn_down, bus.btn_up} ^ {2{BTN_ACT_LOW}};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // NOTE: the two debounce counters are plain flops, not RAM, so they are reset like any register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    db[i]      <= ~db[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + ONE;
                end
            end
        end
    end

    assign db_dir = dir_q ? db[1] : db[0];
    assign db_oth = dir_q ? db[0] : db[1];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (db[0] && !db[1]) begin
                    step_up = 1'b1;
                    dir_d   = 1'b0;
                    timer_d = '0;
                    state_d = S_HOLD;
                end else if (db[1] && !db[0]) begin
                    step_dn = 1'b1;
                    dir_d   = 1'b1;
                    timer_d = '0;
                    state_d = S_HOLD;
                end else if (db[0] && db[1]) begin
                    state_d = S_LOCK;
                end
            end
            S_HOLD: begin
                if (!db_dir) begin
                    state_d = S_IDLE;
                end else if (db_oth) begin
                    state_d = S_LOCK;
                end else if (bus.repeat_en && timer_q >= HOLD_LAST) begin
                    step_up = !dir_q;
                    step_dn = dir_q;
                    timer_d = '0;
                    state_d = S_REPEAT;
                end else if (timer_q < HOLD_LAST) begin
                    // Saturates at the hold threshold so re-enabling repeat fires promptly.
                    timer_d = timer_q + ONE;
                end
            end
            S_REPEAT: begin
                if (!db_dir) begin
                    state_d = S_IDLE;
                end else if (db_oth) begin
                    state_d = S_LOCK;
                end else if (!bus.repeat_en) begin
                    state_d = S_HOLD;
                end else if (timer_q == REP_LAST) begin
                    step_up = !dir_q;
                    step_dn = dir_q;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            S_LOCK: begin
                if (db == 2'b00) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            timer_q <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            up_q    <= step_up;
            down_q  <= step_dn;
            en_q    <= step_up | step_dn;
        end
    end

    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign bus.EN   = en_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Randomized and directed bench for button_step_conditioner: a behavioural model predicts
// every step pulse into a queue, and a separate monitor checks the DUT's strobes against it.
module tb_button_step_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    typedef struct {
        int cyc;
        int dir;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    button_step_conditioner_if bus ();

    button_step_conditioner #(
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (8),
        .BTN_ACT_LOW  (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    ev_t exp_q[$];
    ev_t log_q[$];

    // Model state: synchroniser pipe, debounced levels, runs of disagreement, press tracking.
    int m_s1[2], m_s2[2], m_db[2], m_run[2];
    int m_mode;   // 0 idle, 1 held, 2 locked
    int m_dir;
    int m_t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
        end
        m_mode = 0;
        m_dir  = 0;
        m_t0   = 0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: press/hold/lock decisions use the debounced
    // levels from before the edge; pulses follow the schedule first, +HOLD, then every REP.
    task automatic model_step();
        int raw[2];
        int e;
        raw[0] = int'(bus.btn_up);
        raw[1] = int'(bus.btn_down);
        case (m_mode)
            0: begin
                if (m_db[0] != m_db[1]) begin
                    m_dir  = m_db[0] ? 0 : 1;
                    m_mode = 1;
                    m_t0   = cyc;
                    exp_q.push_back('{cyc: cyc, dir: m_dir});
                end else if (m_db[0] == 1) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (m_db[m_dir] == 0) begin
                    m_mode = 0;
                end else if (m_db[1 - m_dir] == 1) begin
                    m_mode = 2;
                end else if (bus.repeat_en) begin
                    e = cyc - m_t0;
                    if (e >= HOLD && (e - HOLD) % REP == 0)
                        exp_q.push_back('{cyc: cyc, dir: m_dir});
                end
            end
            default: begin
                if (m_db[0] == 0 && m_db[1] == 0) m_mode = 0;
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i]  = 1 - m_db[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Monitor: pops the expected queue whenever the DUT strobes, flags missed pulses.
    initial begin
        ev_t e;
        int  d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
            end else begin
                check("up_down_exclusive", 32'(bus.up & bus.down), 0);
                check("en_equals_up_or_down", 32'(bus.EN), 32'(bus.up | bus.down));
                if (bus.up || bus.down) begin
                    d = bus.down ? 1 : 0;
                    log_q.push_back('{cyc: cyc, dir: d});
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got dir %0d at edge %0d, expected none", d, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_edge", cyc, e.cyc);
                        check("pulse_dir", d, e.dir);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_pulse: got none at edge %0d, expected dir %0d", cyc, e.dir);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input bit u, input bit d);
        bus.btn_up   = u;
        bus.btn_down = d;
    endtask

    initial begin
        int n0, n1, k, kf, kr, cnt, first, last, lastp, exp_cnt, exp_last, d, h;

        set_btn(0, 0);
        bus.repeat_en = 1'b0;
        cycles(3);
        check("reset_up", 32'(bus.up), 0);
        check("reset_down", 32'(bus.down), 0);
        check("reset_en", 32'(bus.EN), 0);
        rst = 1'b1;
        cycles(4);

        // 1: clean up press held 5 cycles, no repeat.
        n0 = log_q.size(); k = cyc + 1;
        set_btn(1, 0); cycles(5); set_btn(0, 0); cycles(20); #1;
        check("t1_count", log_q.size() - n0, 1);
        if (log_q.size() > n0) begin
            check("t1_latency", log_q[n0].cyc - k, DEB + 2);
            check("t1_dir", log_q[n0].dir, 0);
        end

        // 2: down bounces every cycle for 8 cycles, then stays pressed.
        n0 = log_q.size();
        for (int i = 0; i < 8; i++) begin
            set_btn(0, (i % 2) == 0);
            cycles(1);
        end
        kf = cyc + 1;
        set_btn(0, 1); cycles(15); set_btn(0, 0); cycles(20); #1;
        check("t2_count", log_q.size() - n0, 1);
        if (log_q.size() > n0) begin
            check("t2_latency", log_q[n0].cyc - kf, DEB + 2);
            check("t2_dir", log_q[n0].dir, 1);
        end

        // 3: hold up for 40 cycles with auto-repeat.
        bus.repeat_en = 1'b1;
        n0 = log_q.size(); k = cyc + 1;
        set_btn(1, 0); cycles(40); set_btn(0, 0); cycles(20); #1;
        first = DEB + 2;
        lastp = 40 + DEB + 1;
        exp_cnt = 0; exp_last = 0;
        for (int o = first; o <= lastp; o++) begin
            if (o == first || (o - first >= HOLD && (o - first - HOLD) % REP == 0)) begin
                exp_cnt++;
                exp_last = o;
            end
        end
        check("t3_count", log_q.size() - n0, exp_cnt);
        if (log_q.size() > n0 + 1) begin
            check("t3_second_pulse", log_q[n0 + 1].cyc - k, first + HOLD);
            last = log_q[log_q.size() - 1].cyc - k;
            check("t3_last_pulse", last, exp_last);
        end
        bus.repeat_en = 1'b0;
        cycles(5);

        // 4: up pressed, down added (lock), down released, up released, then clean down.
        n0 = log_q.size();
        set_btn(1, 0); cycles(12);
        set_btn(1, 1); cycles(12);
        set_btn(1, 0); cycles(12);
        set_btn(0, 0); cycles(12); #1;
        check("t4_lock_count", log_q.size() - n0, 1);
        n1 = log_q.size();
        set_btn(0, 1); cycles(8); set_btn(0, 0); cycles(12); #1;
        check("t4_after_lock_count", log_q.size() - n1, 1);
        if (log_q.size() > n1) check("t4_after_lock_dir", log_q[n1].dir, 1);

        // 5: both pressed in the same cycle.
        n0 = log_q.size();
        set_btn(1, 1); cycles(20); set_btn(0, 0); cycles(15); #1;
        check("t5_count", log_q.size() - n0, 0);

        // 6: reset during a repeat burst with the button still held.
        bus.repeat_en = 1'b1;
        k = cyc + 1;
        set_btn(1, 0);
        while (cyc < k + DEB + 1 + HOLD + 2 * REP) @(negedge clk);
        @(posedge clk); #1;
        check("t6_burst_pulse", 32'(bus.up), 1);
        rst = 1'b0;
        #1;
        check("t6_async_up", 32'(bus.up), 0);
        check("t6_async_down", 32'(bus.down), 0);
        check("t6_async_en", 32'(bus.EN), 0);
        cycles(3);
        rst = 1'b1;
        kr = cyc;
        n0 = log_q.size();
        cycles(DEB + 6); #1;
        check("t6_pulse_seen", 32'(log_q.size() > n0), 1);
        if (log_q.size() > n0) check("t6_release_latency", log_q[n0].cyc - kr, DEB + 3);
        set_btn(0, 0);
        cycles(DEB + 8);

        // Random segments; repeat_en only changes while everything is released and idle.
        for (int s = 0; s < 40; s++) begin
            bus.repeat_en = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 1);
            h = $urandom_range(1, 30);
            case ($urandom_range(0, 3))
                0: begin
                    set_btn(d == 0, d == 1); cycles(h);
                end
                1: begin
                    cnt = $urandom_range(2, 8);
                    for (int i = 0; i < cnt; i++) begin
                        set_btn(d == 0 && $urandom_range(0, 1) == 1, d == 1 && $urandom_range(0, 1) == 1);
                        cycles(1);
                    end
                    set_btn(d == 0, d == 1); cycles(h);
                end
                2: begin
                    set_btn(d == 0, d == 1); cycles(h);
                    set_btn(1, 1); cycles($urandom_range(1, 12));
                    set_btn(d == 1, d == 0); cycles($urandom_range(1, 12));
                end
                default: begin
                    for (int i = 0; i < 25; i++) begin
                        set_btn($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
                        cycles($urandom_range(1, 6));
                    end
                end
            endcase
            set_btn(0, 0);
            cycles(DEB + 8);
        end

        cycles(5); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
